// File: rtl/mio_bus_responder_if.sv
// MIO bus between the CPU core and the memory/IO responder.
// The master drives requests and the slave returns a one-cycle response strobe with read data.
interface mio_bus_responder_if;
    logic        cpu_mio;
    logic        mem_w;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mio_ready;

    modport master (
        output cpu_mio, mem_w, addr_in, data_in,
        input  data_out, mio_ready
    );

    modport slave (
        input  cpu_mio, mem_w, addr_in, data_in,
        output data_out, mio_ready
    );
endinterface

// File: rtl/mio_bus_responder.sv
// MIO bus responder: word RAM, GPIO LED/switch port and a compare/match counter with irq pulse.
// state  | meaning
// IDLE   | waiting for cpu_mio; accepts and latches a request
// WAIT   | RAM access wait cycles, r_cnt counts down to 1
// RESP   | mio_ready high for one cycle, data_out valid
module mio_bus_responder #(
    parameter int RAM_DEPTH = 1024,
    parameter int RAM_WAIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mio_bus_responder_if.slave    bus,
    input  logic [15:0]           switches,
    output logic [15:0]           led,
    output logic                  timer_irq
);
    localparam int AW = $clog2(RAM_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

    // word addresses (byte address >> 2)
    localparam logic [29:0] A_GPIO = 30'h3800_0000;
    localparam logic [29:0] A_CNT  = 30'h3C00_0000;
    localparam logic [29:0] A_CMP  = 30'h3C00_0001;
    localparam logic [29:0] A_CTL  = 30'h3C00_0002;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_data_out;
    logic [31:0] r_counter;
    logic [31:0] r_compare;
    logic        r_enable;
    logic [15:0] r_led;
    logic        r_irq;
    logic [31:0] r_mem [RAM_DEPTH];

    logic        w_accept;
    logic        w_to_wait;
    logic        w_commit;
    logic [29:0] w_waddr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_sel_ram;
    logic        w_sel_gpio;
    logic        w_sel_cnt;
    logic        w_sel_cmp;
    logic        w_sel_ctl;
    logic [AW-1:0] w_ram_idx;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = &{1'b0, bus.addr_in[1:0]};

    assign w_accept  = (r_state == S_IDLE) && bus.cpu_mio;
    assign w_to_wait = w_accept && (bus.addr_in[31:28] == 4'h0) && (RAM_WAIT != 0);
    assign w_commit  = (w_accept && !w_to_wait) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // A request that goes straight to RESP commits at its accept edge, before the latch is visible.
    assign w_waddr = (r_state == S_IDLE) ? bus.addr_in[31:2] : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? bus.data_in       : r_wdata;
    assign w_we    = (r_state == S_IDLE) ? bus.mem_w         : r_we;

    assign w_sel_ram  = (w_waddr[29:26] == 4'h0);
    assign w_sel_gpio = (w_waddr == A_GPIO);
    assign w_sel_cnt  = (w_waddr == A_CNT);
    assign w_sel_cmp  = (w_waddr == A_CMP);
    assign w_sel_ctl  = (w_waddr == A_CTL);
    assign w_ram_idx  = w_waddr[AW-1:0];

    always_comb begin
        w_rdata = 32'h0;
        if (w_sel_ram)       w_rdata = r_mem[w_ram_idx];
        else if (w_sel_gpio) w_rdata = {16'h0, switches};
        else if (w_sel_cnt)  w_rdata = r_counter;
        else if (w_sel_cmp)  w_rdata = r_compare;
        else if (w_sel_ctl)  w_rdata = {31'h0, r_enable};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 30'h0;
            r_wdata    <= 32'h0;
            r_we       <= 1'b0;
            r_data_out <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cpu_mio) begin
                        r_addr  <= bus.addr_in[31:2];
                        r_wdata <= bus.data_in;
                        r_we    <= bus.mem_w;
                        if (w_to_wait) begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_commit && !w_we) r_data_out <= w_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led     <= 16'h0;
            r_counter <= 32'h0;
            r_compare <= 32'hFFFF_FFFF;
            r_enable  <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_commit && w_we && w_sel_gpio) r_led     <= w_wdata[15:0];
            if (w_commit && w_we && w_sel_cmp)  r_compare <= w_wdata;
            if (w_commit && w_we && w_sel_ctl)  r_enable  <= w_wdata[0];
            // a bus write to the counter overrides both match and increment
            if (w_commit && w_we && w_sel_cnt) begin
                r_counter <= w_wdata;
            end else if (r_enable && (r_counter == r_compare)) begin
                r_counter <= 32'h0;
                r_irq     <= 1'b1;
            end else if (r_enable) begin
                r_counter <= r_counter + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_we && w_sel_ram) r_mem[w_ram_idx] <= w_wdata;
    end

    assign bus.data_out  = r_data_out;
    assign bus.mio_ready = (r_state == S_RESP);
    assign led           = r_led;
    assign timer_irq     = r_irq;
endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: vector table through a scoreboard, plus counter and reset sequences.
module tb_mio_bus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] switches = 16'h0;
    logic [15:0] led;
    logic        timer_irq;

    mio_bus_responder_if bus();

    mio_bus_responder #(.RAM_DEPTH(1024), .RAM_WAIT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .switches(switches), .led(led), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t        vecs [NV];
    logic [31:0] sb [$];
    logic [31:0] last_rd = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          irq_count = 0;
    int          stray = 0;
    bit          expect_ready = 1'b0;

    always @(negedge clk) begin
        if (timer_irq) irq_count++;
        if (!rst && bus.mio_ready && !expect_ready) stray++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns one negedge after the response so the FSM is back in IDLE.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [15:0] sw, input logic [31:0] exp_rd, input int exp_lat,
                       input string name);
        int lat;
        logic [31:0] e;
        e = we ? last_rd : exp_rd;
        if (!we) last_rd = exp_rd;
        sb.push_back(e);
        expect_ready = 1'b1;
        bus.cpu_mio = 1'b1;
        bus.mem_w   = we;
        bus.addr_in = addr;
        bus.data_in = wdata;
        switches    = sw;
        @(negedge clk);
        bus.cpu_mio = 1'b0;
        bus.mem_w   = ~we;
        bus.addr_in = addr ^ 32'h5555_5555;
        bus.data_in = ~wdata;
        lat = 1;
        while (!bus.mio_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        e = sb.pop_front();
        if (bus.mio_ready) check({name, " data_out"}, bus.data_out, e);
        @(negedge clk);
        expect_ready = 1'b0;
    endtask

    initial begin
        int n;
        int irq_snap;
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0,         2};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 2};
        vecs[2]  = '{1'b0, 32'h0000_1010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 2};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 16'h0000, 32'h0,         2};
        vecs[4]  = '{1'b1, 32'hE000_0000, 32'h1234_A5A5, 16'h0000, 32'h0,         1};
        vecs[5]  = '{1'b0, 32'hE000_0000, 32'h0,         16'h00FF, 32'h0000_00FF, 1};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         16'h00FF, 32'h0,         1};
        vecs[7]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 16'h00FF, 32'h0,         1};
        vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h00FF, 32'hDEAD_BEEF, 2};
        vecs[9]  = '{1'b0, 32'hE000_0003, 32'h0,         16'hBEEF, 32'h0000_BEEF, 1};
        vecs[10] = '{1'b0, 32'hF000_0004, 32'h0,         16'hBEEF, 32'hFFFF_FFFF, 1};
        vecs[11] = '{1'b0, 32'hF000_0008, 32'h0,         16'hBEEF, 32'h0,         1};
        vecs[12] = '{1'b0, 32'hF000_0000, 32'h0,         16'hBEEF, 32'h0,         1};

        bus.cpu_mio = 1'b0;
        bus.mem_w   = 1'b0;
        bus.addr_in = 32'h0;
        bus.data_in = 32'h0;
        repeat (3) @(negedge clk);
        check("reset mio_ready", {31'h0, bus.mio_ready}, 32'h0);
        check("reset data_out", bus.data_out, 32'h0);
        check("reset led", {16'h0, led}, 32'h0);
        check("reset timer_irq", {31'h0, timer_irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw, vecs[i].exp, vecs[i].lat,
                $sformatf("vec%0d", i));
        check("led after gpio write", {16'h0, led}, 32'h0000_A5A5);

        // counter with compare=5: first match, pulse width, period, read-back, freeze
        txn(1'b1, 32'hF000_0004, 32'd5, 16'h0, 32'h0, 1, "wr compare");
        txn(1'b1, 32'hF000_0008, 32'd1, 16'h0, 32'h0, 1, "wr enable");
        n = 0;
        while (!timer_irq && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first irq delay", n, 5);
        @(negedge clk);
        check("irq pulse width", {31'h0, timer_irq}, 32'h0);
        n = 1;
        while (!timer_irq && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("irq period", n, 6);
        txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'd0, 1, "rd counter after match");
        txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'd2, 1, "rd counter running");
        txn(1'b1, 32'hF000_0008, 32'd0, 16'h0, 32'h0, 1, "wr disable");
        txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'd5, 1, "rd counter frozen");
        irq_snap = irq_count;
        repeat (20) @(negedge clk);
        check("no irq while disabled", irq_count - irq_snap, 0);
        txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'd5, 1, "rd counter still frozen");

        // counter write colliding with an increment, then with a match
        txn(1'b1, 32'hF000_0004, 32'h64, 16'h0, 32'h0, 1, "wr compare 0x64");
        txn(1'b1, 32'hF000_0008, 32'd1, 16'h0, 32'h0, 1, "wr enable again");
        txn(1'b1, 32'hF000_0000, 32'h100, 16'h0, 32'h0, 1, "wr counter vs increment");
        txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'h101, 1, "rd counter after incr collision");
        txn(1'b1, 32'hF000_0004, 32'd5, 16'h0, 32'h0, 1, "wr compare 5");
        txn(1'b1, 32'hF000_0000, 32'd3, 16'h0, 32'h0, 1, "wr counter 3");
        @(negedge clk);
        irq_snap = irq_count;
        txn(1'b1, 32'hF000_0000, 32'h100, 16'h0, 32'h0, 1, "wr counter vs match");
        check("no irq on match collision", irq_count - irq_snap, 0);
        txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 32'h101, 1, "rd counter after match collision");

        // reset while a RAM write sits in WAIT
        bus.cpu_mio = 1'b1;
        bus.mem_w   = 1'b1;
        bus.addr_in = 32'h0000_0020;
        bus.data_in = 32'h2222_2222;
        @(negedge clk);
        bus.cpu_mio = 1'b0;
        rst = 1'b1;
        #1;
        check("mio_ready during reset", {31'h0, bus.mio_ready}, 32'h0);
        check("data_out during reset", bus.data_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        txn(1'b0, 32'h0000_0020, 32'h0, 16'h0, 32'h1111_1111, 2, "rd ram after dropped write");
        txn(1'b0, 32'hF000_0008, 32'h0, 16'h0, 32'h0, 1, "rd control after reset");
        check("led after reset", {16'h0, led}, 32'h0);
        check("stray mio_ready cycles", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Memory/IO-side responder for the pipelined CPU's MIO bus. It accepts word requests (CPU_MIO, mem_ifWriteMem, Address_out, Data_out) and returns read data and MIO_ready.
- It decodes three regions: word-addressed data RAM, a GPIO LED/switch port, and a programmable counter with an interrupt pulse.
- It sits between the CPU top and the board I/O, and supplies the CPU's Data_in, MIO_ready and INT inputs.

Parameters:
- RAM_DEPTH, 1024, data RAM size in 32-bit words (power of two).
- RAM_WAIT, 1, extra wait cycles for RAM accesses (0..15).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_mio  input  1  request valid from the CPU (CPU_MIO).
- mem_w  input  1  1 = write, 0 = read (mem_ifWriteMem).
- addr_in  input  32  byte address (Address_out); bits [1:0] ignored.
- data_in  input  32  write data (Data_out).
- data_out  output  32  read data to the CPU (Data_in).
- mio_ready  output  1  one-cycle response strobe (MIO_ready).
- switches  input  16  board switches.
- led  output  16  LED register.
- timer_irq  output  1  one-cycle counter-match pulse (INT).

Behaviour:
- Reset (async, immediate): state=IDLE, data_out=0, mio_ready=0, led=0, timer_irq=0, counter=0, compare=32'hFFFF_FFFF, enable=0. RAM contents are not reset.
- Address map (decode on the latched address):
  - addr[31:28]=0x0: RAM word at addr[log2(RAM_DEPTH)+1:2]; higher bits inside the region alias.
  - 0xE000_0000: read {16'b0,switches}; write led <= data[15:0].
  - 0xF000_0000: counter (R/W).
  - 0xF000_0004: compare (R/W).
  - 0xF000_0008: control, bit0=enable (R/W; other bits read 0).
  - Anything else: reads return 0, writes are ignored, and the request is still acknowledged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: cpu_mio=1 at an edge accepts the request. Latch addr, data and mem_w. RAM region with RAM_WAIT>0 goes to WAIT with cnt=RAM_WAIT. Otherwise go to RESP directly.
  - WAIT: cnt decrements each edge; at the edge where cnt==1, go to RESP.
  - RESP: mio_ready=1 for exactly this one cycle; data_out is valid this cycle. Always return to IDLE at the next edge. cpu_mio is not sampled in RESP, so back-to-back requests are accepted from IDLE one cycle later.
- Commit: a write commits, and read data registers into data_out, at the edge that enters RESP.
- data_out holds its last value outside RESP. After a write it holds its prior value.
- Latency from the accept edge to mio_ready high: peripheral/unmapped = 1 cycle; RAM = 1+RAM_WAIT cycles.
- Inputs changing after acceptance have no effect (the request is latched).
- Counter, each edge:
  - If a bus write to the counter commits, counter <= data; it wins over increment and match.
  - Else if enable and counter==compare: counter <= 0 and timer_irq=1 for one cycle.
  - Else if enable: counter += 1, wrapping at 32 bits.
  - With enable=0 the counter holds and no irq is generated.
- Compare write at the same edge as a match: the match uses the old compare value.
- A read of the counter returns the value before that edge's update.
- Reset mid-operation: FSM returns to IDLE and any uncommitted write is dropped; mio_ready drops at once.

Test Plan:
- Reset, then RAM write 0x0000_0010 <= 0xDEAD_BEEF, then read 0x0000_0010 (RAM_WAIT=1) -> mio_ready high in the 2nd cycle after each accept edge; read data_out=0xDEAD_BEEF; unaccessed cycles keep mio_ready=0.
- Write 0xE000_0000 <= 0x1234_A5A5; set switches=0x00FF and read 0xE000_0000 -> led=0xA5A5 after the commit edge; read data_out=0x0000_00FF with 1-cycle latency.
- Write compare=5, control=1 -> counter counts 0..5; timer_irq is a single-cycle pulse when counter==5, counter then reads 0, 1, ...; with control=0 the counter freezes and there is no irq.
- Counter write 0x100 issued in the same cycle as an increment and in the same cycle as a match -> counter=0x100 next cycle in both cases, with no irq in the match-collision case.
- Read 0x8000_0000 and write 0x8000_0000 -> data_out=0 and mio_ready pulses after 1 cycle; no RAM, LED or timer state changes.
- Assert rst during WAIT of a RAM write to 0x20 -> mio_ready=0 at once, FSM returns to IDLE, and a later read of 0x20 returns the old contents.
